// File: rtl/mmm_seq.sv
// Sequential radix-2 Montgomery modular multiplier.
// The block computes y = a*b*2^-N mod n. It scans K bits of a per clock over
// N/K RUN cycles, then spends one FINAL cycle on a conditional subtraction.
// A start/done handshake lets a controller chain multiplications back to back.
module mmm_seq #(
    parameter int N = 32,
    parameter int K = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] n,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] y
);

    localparam int            STEPS = N / K;
    localparam int            CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST  = CW'(STEPS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FINAL = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [N:0]    s;        // partial sum; S < 2n holds, so N+1 bits suffice
    logic [N-1:0]  a_sh;     // multiplicand, consumed LSB first
    logic [N-1:0]  b_r;
    logic [N-1:0]  n_r;

    logic [N+1:0]  num;      // one iteration's numerator, always even after the q*n add
    logic [N:0]    s_acc;
    logic [N:0]    s_next;
    logic [N:0]    s_red;

    // K chained Montgomery iterations applied to S within one clock.
    always_comb begin
        // NOTE: every variable gets a default before any branch so that no latch is inferred.
        num   = '0;
        s_acc = s;
        for (int i = 0; i < K; i++) begin
            num = {1'b0, s_acc} + (a_sh[i] ? {2'b00, b_r} : '0);
            // q = parity of (S + a_i*b); adding the odd modulus makes the sum even.
            if (num[0]) begin
                num = num + {2'b00, n_r};
            end
            s_acc = num[N+1:1];
        end
        s_next = s_acc;
    end

    // The final conditional subtraction brings S from [0, 2n) into [0, n).
    always_comb begin
        s_red = (s >= {1'b0, n_r}) ? (s - {1'b0, n_r}) : s;
    end

    // Control FSM and datapath registers: IDLE -> RUN (N/K edges) -> FINAL -> IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the operand registers are plain flops, not RAM, so they are reset to keep X out of y.
            state <= IDLE;
            cnt   <= '0;
            s     <= '0;
            a_sh  <= '0;
            b_r   <= '0;
            n_r   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            y     <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the values from before the edge.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_r   <= b;
                        n_r   <= n;
                        s     <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    s    <= s_next;
                    a_sh <= a_sh >> K;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= FINAL;
                    end
                end
                FINAL: begin
                    y     <= s_red[N-1:0];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
